// File: rtl/lcd_char_driver.sv
// HD44780 8-bit-mode driver: power-up wait, init sequence, then refreshes a 2x16 display from a 32-byte buffer.
// Optional macro LCD_DIRTY_REFRESH_EN: after a full pass, idle until the buffer is written again.
module lcd_char_driver #(
    parameter int POWERUP_CYC = 750000,
    parameter int CMD_CYC     = 2000,
    parameter int CLR_CYC     = 82000,
    parameter int E_PULSE_CYC = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [4:0] wadd,
    input  logic [7:0] din,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_db,
    output logic       init_done
);
    localparam int MAX_AB  = (POWERUP_CYC > CLR_CYC) ? POWERUP_CYC : CLR_CYC;
    localparam int MAX_CD  = (CMD_CYC > E_PULSE_CYC) ? CMD_CYC : E_PULSE_CYC;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {PWR_WAIT, INIT, ADDR1, LINE1, ADDR2, LINE2, IDLE} state_t;
    typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_HOLD} phase_t;

    state_t           state, state_nxt;
    phase_t           phase, phase_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] hold_last;
    logic [3:0]       idx, idx_nxt;
    logic [7:0]       db_q, db_nxt;
    logic             rs_q, rs_nxt;
    logic             init_done_nxt;
    logic [7:0]       buffer [32];
    logic [7:0]       fetch_db;
    logic             fetch_rs;
    logic             in_xfer;
    logic             setup;
`ifdef LCD_DIRTY_REFRESH_EN
    logic             dirty, dirty_nxt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) buffer[i] <= 8'h20;
        end else if (we) begin
            buffer[wadd] <= din;
        end
    end

    // Byte and register select for the transfer currently in its setup cycle
    always_comb begin
        fetch_db = 8'h00;
        fetch_rs = 1'b0;
        case (state)
            INIT: begin
                case (idx[1:0])
                    2'd0:    fetch_db = 8'h38;
                    2'd1:    fetch_db = 8'h0C;
                    2'd2:    fetch_db = 8'h01;
                    default: fetch_db = 8'h06;
                endcase
            end
            ADDR1: fetch_db = 8'h80;
            ADDR2: fetch_db = 8'hC0;
            LINE1: begin
                fetch_db = buffer[{1'b0, idx}];
                fetch_rs = 1'b1;
            end
            LINE2: begin
                fetch_db = buffer[{1'b1, idx}];
                fetch_rs = 1'b1;
            end
            default: ;
        endcase
    end

    // db/rs follow the fetch only while e is low in setup, then stay latched until the next setup
    assign in_xfer   = state inside {INIT, ADDR1, LINE1, ADDR2, LINE2};
    assign setup     = in_xfer && (phase == PH_SETUP);
    assign lcd_e     = in_xfer && (phase == PH_PULSE);
    assign lcd_db    = setup ? fetch_db : db_q;
    assign lcd_rs    = setup ? fetch_rs : rs_q;
    assign lcd_rw    = 1'b0;
    assign hold_last = (db_q == 8'h01 && !rs_q) ? CNT_W'(CLR_CYC - 1) : CNT_W'(CMD_CYC - 1);

    always_comb begin
        state_nxt     = state;
        phase_nxt     = phase;
        cnt_nxt       = cnt;
        idx_nxt       = idx;
        db_nxt        = db_q;
        rs_nxt        = rs_q;
        init_done_nxt = init_done;
`ifdef LCD_DIRTY_REFRESH_EN
        dirty_nxt     = dirty | we;
`endif
        case (state)
            PWR_WAIT: begin
                if (cnt == CNT_W'(POWERUP_CYC - 1)) begin
                    state_nxt = INIT;
                    phase_nxt = PH_SETUP;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
`ifdef LCD_DIRTY_REFRESH_EN
            IDLE: begin
                if (dirty) begin
                    state_nxt = ADDR1;
                    phase_nxt = PH_SETUP;
                    idx_nxt   = '0;
                    dirty_nxt = we;
                end
            end
`endif
            default: begin
                case (phase)
                    PH_SETUP: begin
                        phase_nxt = PH_PULSE;
                        cnt_nxt   = '0;
                        db_nxt    = fetch_db;
                        rs_nxt    = fetch_rs;
                    end
                    PH_PULSE: begin
                        if (cnt == CNT_W'(E_PULSE_CYC - 1)) begin
                            phase_nxt = PH_HOLD;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                    default: begin
                        if (cnt == hold_last) begin
                            phase_nxt = PH_SETUP;
                            cnt_nxt   = '0;
                            idx_nxt   = idx + 1'b1;
                            case (state)
                                INIT: begin
                                    if (idx == 4'd3) begin
                                        state_nxt     = ADDR1;
                                        idx_nxt       = '0;
                                        init_done_nxt = 1'b1;
`ifdef LCD_DIRTY_REFRESH_EN
                                        dirty_nxt     = we;
`endif
                                    end
                                end
                                ADDR1: begin
                                    state_nxt = LINE1;
                                    idx_nxt   = '0;
                                end
                                LINE1: if (idx == 4'd15) state_nxt = ADDR2;
                                ADDR2: begin
                                    state_nxt = LINE2;
                                    idx_nxt   = '0;
                                end
                                LINE2: begin
                                    if (idx == 4'd15) begin
`ifdef LCD_DIRTY_REFRESH_EN
                                        if (dirty) begin
                                            state_nxt = ADDR1;
                                            dirty_nxt = we;
                                        end else begin
                                            state_nxt = IDLE;
                                        end
`else
                                        state_nxt = ADDR1;
`endif
                                    end
                                end
                                default: ;
                            endcase
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= PWR_WAIT;
            phase     <= PH_SETUP;
            cnt       <= '0;
            idx       <= '0;
            db_q      <= 8'h00;
            rs_q      <= 1'b0;
            init_done <= 1'b0;
`ifdef LCD_DIRTY_REFRESH_EN
            dirty     <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            phase     <= phase_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            db_q      <= db_nxt;
            rs_q      <= rs_nxt;
            init_done <= init_done_nxt;
`ifdef LCD_DIRTY_REFRESH_EN
            dirty     <= dirty_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_lcd_char_driver.sv
// Bench for lcd_char_driver: a transfer-schedule model (start cycles from period arithmetic,
// bytes from a shadow buffer) predicts every bus cycle under random buffer writes.
`timescale 1ns/1ps
module tb_lcd_char_driver;
    localparam int P   = 10;
    localparam int CMD = 4;
    localparam int CLR = 8;
    localparam int E   = 2;
`ifdef LCD_DIRTY_REFRESH_EN
    localparam bit DIRTY = 1'b1;
`else
    localparam bit DIRTY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       we = 1'b0;
    logic [4:0] wadd = '0;
    logic [7:0] din = '0;
    logic       lcd_e, lcd_rs, lcd_rw, init_done;
    logic [7:0] lcd_db;

    int checks = 0;
    int errors = 0;

    lcd_char_driver #(
        .POWERUP_CYC(P), .CMD_CYC(CMD), .CLR_CYC(CLR), .E_PULSE_CYC(E)
    ) dut (
        .clk(clk), .reset(reset), .we(we), .wadd(wadd), .din(din),
        .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_db(lcd_db),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic [7:0] mbuf [32];
    int   k, p, cur_start, next_start;
    logic [7:0] cur_db;
    logic cur_rs;
    bit   idle, pending_idle, dirty, init_exp, rst_prev;
    // Stimulus controls
    int   wr_pct, hold_reset;
    bit   w16_req, col5_req, mid_reset_req, mid_reset_done, w_once_req;

    function automatic int hold_of(int pp);
        return (pp == 2) ? CLR : CMD;
    endfunction

    function automatic int pass_pos(int pp);
        return (pp < 4) ? -1 : (pp - 4) % 34;
    endfunction

    // {rs, db} of transfer number pp, taken from the shadow buffer as it is now
    function automatic logic [8:0] item_of(int pp);
        int q;
        if (pp < 4) begin
            case (pp)
                0:       return 9'h038;
                1:       return 9'h00C;
                2:       return 9'h001;
                default: return 9'h006;
            endcase
        end
        q = pass_pos(pp);
        if (q == 0)  return 9'h080;
        if (q <= 16) return {1'b1, mbuf[q - 1]};
        if (q == 17) return 9'h0C0;
        return {1'b1, mbuf[q - 2]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
        k = 0; p = -1; cur_start = 0; next_start = P;
        cur_db = 8'h00; cur_rs = 1'b0;
        idle = 0; pending_idle = 0; dirty = 0; init_exp = 0;
    endtask

    task automatic step();
        logic [8:0] it;
        int  off;
        bit  e_exp;
        @(negedge clk);
        if (rst_prev) model_reset();
        else k++;

        if (k == next_start) begin
            if (pending_idle) begin
                pending_idle = 0;
                idle = 1;
                next_start = 1 << 30;
            end else begin
                p++;
                it = item_of(p);
                cur_rs = it[8];
                cur_db = it[7:0];
                cur_start = k;
                next_start = k + 1 + E + hold_of(p);
                if (p == 4) init_exp = 1;
            end
        end
        if (idle && dirty) begin
            idle = 0;
            dirty = 0;
            next_start = k + 1;
        end

        off = k - cur_start;
        e_exp = (p >= 0) && !idle && (off >= 1) && (off <= E);
        check($sformatf("lcd_e@%0d", k), 32'(lcd_e), 32'(e_exp));
        check($sformatf("lcd_rs@%0d", k), 32'(lcd_rs), 32'(cur_rs));
        check($sformatf("lcd_db@%0d", k), 32'(lcd_db), 32'(cur_db));
        check($sformatf("lcd_rw@%0d", k), 32'(lcd_rw), 32'd0);
        check($sformatf("init_done@%0d", k), 32'(init_done), 32'(init_exp));

        // Decisions taken in the last hold cycle of a transfer
        if (!idle && p >= 0 && k == next_start - 1 && off == E + hold_of(p)) begin
            if (p == 3) dirty = 0;
            else if (DIRTY && pass_pos(p) == 33) begin
                if (dirty) dirty = 0;
                else pending_idle = 1;
            end
        end

        reset = 1'b0;
        we = 1'b0;
        if (hold_reset > 0) begin
            hold_reset--;
            reset = 1'b1;
            we = 1'b1;
            wadd = 5'($urandom_range(31));
            din = 8'($urandom_range(255));
        end else if (mid_reset_req && e_exp && pass_pos(p) >= 1 && pass_pos(p) <= 16) begin
            mid_reset_req = 0;
            mid_reset_done = 1;
            reset = 1'b1;
        end else if (w16_req && p < 0 && k == 3) begin
            w16_req = 0;
            we = 1'b1; wadd = 5'd16; din = 8'h49;
        end else if (col5_req && !idle && k == cur_start && pass_pos(p) == 6) begin
            col5_req = 0;
            we = 1'b1; wadd = 5'd5; din = 8'h37;
        end else if (w_once_req) begin
            w_once_req = 0;
            we = 1'b1; wadd = 5'd0; din = 8'h41;
        end else if (int'($urandom_range(99)) < wr_pct) begin
            we = 1'b1;
            wadd = 5'($urandom_range(31));
            din = 8'($urandom_range(8'h21, 8'h7E));
        end
        if (we && !reset) begin
            mbuf[wadd] = din;
            dirty = 1;
        end
        rst_prev = reset;
    endtask

    initial begin
        model_reset();
        rst_prev = 0; wr_pct = 0; hold_reset = 0;
        w16_req = 0; col5_req = 0; mid_reset_req = 0; mid_reset_done = 0; w_once_req = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        rst_prev = 1;

        // Reset with ignored writes, a write during power-up, then two quiet passes
        hold_reset = 3;
        w16_req = 1;
        col5_req = 1;
        repeat (P + 32 + 2 * 238 + 20) step();

        wr_pct = 6;
        repeat (600) step();

        mid_reset_req = 1;
        for (int i = 0; i < 600 && mid_reset_req; i++) step();
        check("mid_reset_seen", 32'(mid_reset_done), 32'd1);
        repeat (400) step();

`ifdef LCD_DIRTY_REFRESH_EN
        wr_pct = 0;
        repeat (600) step();
        repeat (1000) step();
        check("idle_after_quiet", 32'(idle), 32'd1);
        w_once_req = 1;
        repeat (400) step();
        check("idle_after_one_pass", 32'(idle), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lcd_char_driver.md
LCD_CHAR_DRIVER -- requirements
Module: lcd_char_driver

Interface
REQ-001 SHALL have parameter POWERUP_CYC, default 750000, power-on wait in clk cycles (15 ms at 50 MHz).
REQ-002 SHALL have parameter CMD_CYC, default 2000, post-transfer wait for normal commands and data (40 us).
REQ-003 SHALL have parameter CLR_CYC, default 82000, post-transfer wait after clear command 0x01 (1.64 ms).
REQ-004 SHALL have parameter E_PULSE_CYC, default 12, cycles lcd_e is held high per transfer.
REQ-005 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-007 SHALL have port we, input, 1, character buffer write strobe, sampled every clk.
REQ-008 SHALL have port wadd, input, 5, buffer address; 0-15 = line 1 col 0-15, 16-31 = line 2 col 0-15.
REQ-009 SHALL have port din, input, 8, ASCII character to store.
REQ-010 SHALL have port lcd_e, output, 1, HD44780 enable strobe.
REQ-011 SHALL have port lcd_rs, output, 1, 0 = command, 1 = data.
REQ-012 SHALL have port lcd_rw, output, 1, constant 0 (write only).
REQ-013 SHALL have port lcd_db, output, 8, LCD data bus, 8-bit mode.
REQ-014 SHALL have port init_done, output, 1, high once the init sequence has completed.

Function
REQ-015 SHALL hold a 32x8 character buffer; a cycle with we=1 writes din to buffer[wadd], visible to fetches from the next cycle.
REQ-016 SHALL accept writes in every state, including power-up wait and init; no write is ever dropped.
REQ-017 SHALL sequence states PWR_WAIT -> INIT -> ADDR1 -> LINE1 -> ADDR2 -> LINE2 -> ADDR1 (continuous loop).
REQ-018 PWR_WAIT SHALL count POWERUP_CYC cycles with lcd_e=0, then enter INIT.
REQ-019 INIT SHALL issue commands 0x38, 0x0C, 0x01, 0x06 in order (rs=0), then assert init_done and enter ADDR1.
REQ-020 ADDR1 SHALL issue command 0x80; LINE1 SHALL write buffer[0..15] (rs=1); ADDR2 SHALL issue 0xC0; LINE2 SHALL write buffer[16..31].
REQ-021 Each transfer SHALL be: 1 setup cycle (rs, db driven, e=0), E_PULSE_CYC cycles e=1, then e=0 with rs/db held for CMD_CYC cycles (CLR_CYC after 0x01).
REQ-022 Transfer period SHALL therefore be 1+E_PULSE_CYC+CMD_CYC cycles (1+E_PULSE_CYC+CLR_CYC for clear).
REQ-023 Character data SHALL be read from the buffer in the setup cycle; a write to the same address in that cycle is shown on the next pass.
REQ-024 lcd_rs and lcd_db SHALL never change while lcd_e=1.
REQ-025 Wait counters SHALL be wide enough for the largest parameter; no wrap-around before terminal count.

Reset
REQ-026 Reset SHALL force lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_db=0x00, init_done=0, state PWR_WAIT, counters 0, one cycle after reset is sampled high.
REQ-027 Reset SHALL fill all 32 buffer entries with 0x20 (space); we is ignored while reset=1.
REQ-028 Reset mid-transfer (including e=1) SHALL drop lcd_e the next cycle and restart the full power-up wait and init.

Configuration
REQ-029 With macro LCD_DIRTY_REFRESH_EN defined, a dirty flag SHALL be set by any we; after LINE2, if dirty=0 the block SHALL idle (e=0, outputs held) until the next we, else clear dirty and restart at ADDR1; the first pass after init SHALL always run.
REQ-030 A we in the same cycle dirty is cleared SHALL leave dirty=1.
REQ-031 Without LCD_DIRTY_REFRESH_EN, refresh SHALL loop continuously per REQ-017 and no dirty flag SHALL exist.

Verification (POWERUP_CYC=10, CMD_CYC=4, CLR_CYC=8, E_PULSE_CYC=2)
REQ-032 Release reset -> lcd_e stays 0 for 10 cycles, then db=0x38,0x0C,0x01,0x06 with rs=0, 7-cycle periods except 11 after 0x01, then init_done=1.
REQ-033 No writes after init -> db=0x80 rs=0, then 16 transfers of 0x20 rs=1, then 0xC0, then 16 of 0x20.
REQ-034 we with wadd=16, din=0x49 during PWR_WAIT -> first LINE2 data transfer shows db=0x49, rs=1.
REQ-035 we wadd=5 din=0x37 in setup cycle of column 5 -> 0x20 displayed this pass, 0x37 next pass.
REQ-036 reset=1 while lcd_e=1 in LINE1 -> lcd_e=0 next cycle, init_done=0, buffer back to spaces, PWR_WAIT restarts.
REQ-037 With LCD_DIRTY_REFRESH_EN, no we after first pass -> lcd_e stays 0 for 1000 cycles; one we -> exactly one further pass.
